spi: RTL and testbench
======================

// Module: spi
// PURPOSE
// - Byte-wide SPI master (mode 0, CPOL=0/CPHA=0), single clock domain.
// - Used by the flash test/controller FSMs to send a command byte or clock in a response byte.
// - Chip select is not handled here; the caller drives CS.
// - One-cycle start strobes in; busy/ready flag (wait_n) out.
// PARAMETERS
// - none (fixed 8-bit frame, SCK = clk/2)
// PORTS
// clk           in   1  system clock (already reduced to <=4 MHz flash-safe rate by caller)
// rst           in   1  reset; synchronous, active-high
// enviar_dato   in   1  start strobe: transmit din
// recibir_dato  in   1  start strobe: receive a byte (transmits 0xFF)
// din           in   8  byte to transmit
// dout          out  8  last received byte
// wait_n        out  1  1 = idle/ready, 0 = transfer in progress
// spi_clk       out  1  SCK
// spi_di        out  1  MOSI (flash DI)
// spi_do        in   1  MISO (flash DO)
// BEHAVIOUR
// - Reset values: wait_n=1, spi_clk=0, spi_di=1, dout=8'h00, FSM=IDLE, bit counter=0.
// - Reset mid-transfer aborts immediately; the same reset values apply and no dout update occurs.
// - States: IDLE, XFER.
// - IDLE, edge T0 with enviar_dato=1:
//   - load shreg=din; kind=SEND; wait_n<=0; spi_di<=din[7]; cnt<=0; go XFER.
// - IDLE, edge T0 with recibir_dato=1 (and enviar_dato=0):
//   - load shreg=8'hFF; kind=RECV; same as above otherwise.
//   - Both strobes high: SEND wins.
// - wait_n is registered low at T0 itself.
//   - A caller that deasserts the strobe at T1 and polls at T2 sees wait_n=0.
// - XFER: cnt increments every edge, T1..T16.
//   - Odd edges T(2k+1): spi_clk<=1; rx<={rx[6:0],spi_do}.
//     Slave samples MOSI on this rising SCK; MISO has been stable since the previous falling SCK.
//   - Even edges T(2k+2), k<7: spi_clk<=0; spi_di<=next bit (MSB first).
//   - Edge T16: spi_clk<=0; spi_di<=1; wait_n<=1; go IDLE.
//     dout<=rx only for RECV transfers; SEND leaves dout unchanged.
// - Per byte: exactly 8 SCK rising edges, SCK high/low one clk each.
//   - wait_n is low for exactly 16 clk cycles (T0..T15 edges).
// - Strobes sampled while in XFER are ignored (not queued).
// - A strobe held high at T16 is not sampled.
//   - A new transfer starts no earlier than T17, on the first IDLE edge where a strobe is high.
// - dout holds its value between transfers; spi_di idles 1, spi_clk idles 0.
// CONFIGURATION
// - Macro SPI_LSB_FIRST_EN.
// - Defined:
//   - transmit order is din[0] first.
//   - received bits are assembled LSB first: rx<={spi_do,rx[7:1]}.
// - Undefined (default): MSB first in both directions, as above.
// TESTING
// - Reset, then idle: wait_n=1, spi_clk=0, spi_di=1, dout=00 -> stable for 100 clk.
// - Send 0x9F:
//   - MOSI at the 8 SCK rises = 1,0,0,1,1,1,1,1.
//   - wait_n low 16 cycles.
//   - dout unchanged.
// - Receive with slave model shifting 0xEF on SCK falling edges:
//   - dout=0xEF when wait_n rises.
//   - spi_di=1 throughout.
// - JEDEC sequence: send 0x9F, then receive (slave returns 0xC2) -> dout=0xC2.
//   - 16 SCK rises total.
//   - No SCK activity between bytes.
// - Robustness:
//   - Pulse recibir_dato at cycle 5 of a SEND -> ignored; still exactly 8 rises.
//   - Assert rst at cycle 7 -> outputs return to reset values next edge.
// - SPI_LSB_FIRST_EN defined:
//   - send 0x9F -> MOSI 1,1,1,1,1,0,0,1.
//   - receive of slave bitstream 1,1,1,1,0,1,1,1 -> dout=0xEF.

Source files
------------

// File: rtl/spi.sv
// spi: byte-wide SPI master, mode 0 (CPOL=0/CPHA=0), SCK = clk/2, caller drives CS.
// Optional feature: define SPI_LSB_FIRST_EN to shift LSB first in both directions;
// the default build shifts MSB first.
module spi (
  input  logic       clk,
  input  logic       rst,
  input  logic       enviar_dato,
  input  logic       recibir_dato,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       wait_n,
  output logic       spi_clk,
  output logic       spi_di,
  input  logic       spi_do
);

  typedef enum logic [0:0] {StIdle, StXfer} state_e;

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] dout_q, dout_d;
  logic       recv_q, recv_d;
  logic       wait_n_q, wait_n_d;
  logic       spi_clk_q, spi_clk_d;
  logic       spi_di_q, spi_di_d;
  logic [7:0] load;

  // State and output registers; reset aborts any transfer without touching dout further.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 5'd0;
      shreg_q   <= 8'h00;
      rx_q      <= 8'h00;
      dout_q    <= 8'h00;
      recv_q    <= 1'b0;
      wait_n_q  <= 1'b1;
      spi_clk_q <= 1'b0;
      spi_di_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      rx_q      <= rx_d;
      dout_q    <= dout_d;
      recv_q    <= recv_d;
      wait_n_q  <= wait_n_d;
      spi_clk_q <= spi_clk_d;
      spi_di_q  <= spi_di_d;
    end
  end

  // Next-state logic: even cnt values precede a rising SCK, odd ones a falling SCK.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    rx_d      = rx_q;
    dout_d    = dout_q;
    recv_d    = recv_q;
    wait_n_d  = wait_n_q;
    spi_clk_d = spi_clk_q;
    spi_di_d  = spi_di_q;
    // A receive clocks out all ones; send wins when both strobes are high.
    load      = enviar_dato ? din : 8'hFF;

    unique case (state_q)
      StIdle: begin
        if (enviar_dato || recibir_dato) begin
          shreg_d  = load;
          recv_d   = ~enviar_dato;
          wait_n_d = 1'b0;
          cnt_d    = 5'd0;
          state_d  = StXfer;
`ifdef SPI_LSB_FIRST_EN
          spi_di_d = load[0];
`else
          spi_di_d = load[7];
`endif
        end
      end
      StXfer: begin
        cnt_d = cnt_q + 5'd1;
        if (!cnt_q[0]) begin
          // Rising SCK: slave samples MOSI, master samples MISO.
          spi_clk_d = 1'b1;
`ifdef SPI_LSB_FIRST_EN
          rx_d = {spi_do, rx_q[7:1]};
`else
          rx_d = {rx_q[6:0], spi_do};
`endif
        end else if (cnt_q == 5'd15) begin
          // Last falling SCK: release the bus and report completion.
          spi_clk_d = 1'b0;
          spi_di_d  = 1'b1;
          wait_n_d  = 1'b1;
          state_d   = StIdle;
          if (recv_q) begin
            dout_d = rx_q;
          end
        end else begin
          // Falling SCK: present the next outgoing bit.
          spi_clk_d = 1'b0;
`ifdef SPI_LSB_FIRST_EN
          shreg_d  = {1'b0, shreg_q[7:1]};
          spi_di_d = shreg_q[1];
`else
          shreg_d  = {shreg_q[6:0], 1'b0};
          spi_di_d = shreg_q[6];
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign dout    = dout_q;
  assign wait_n  = wait_n_q;
  assign spi_clk = spi_clk_q;
  assign spi_di  = spi_di_q;

endmodule

// File: tb/tb_spi.sv
// tb_spi: randomized scoreboard bench for the spi master with a behavioural slave model.
module tb_spi;

  logic       clk;
  logic       rst;
  logic       enviar_dato;
  logic       recibir_dato;
  logic [7:0] din;
  logic [7:0] dout;
  logic       wait_n;
  logic       spi_clk;
  logic       spi_di;
  logic       spi_do;

  spi dut (
    .clk          (clk),
    .rst          (rst),
    .enviar_dato  (enviar_dato),
    .recibir_dato (recibir_dato),
    .din          (din),
    .dout         (dout),
    .wait_n       (wait_n),
    .spi_clk      (spi_clk),
    .spi_di       (spi_di),
    .spi_do       (spi_do)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] seq;   // MOSI bits in wire order, first bit at [7]
    logic [7:0] dout;  // dout once the byte completes
    logic       recv;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  bit         mon_en = 0;
  logic [7:0] dout_model = 8'h00;

  // Slave: presents the first bit up front, then advances on each falling SCK.
  logic [7:0] slave_seq = 8'hFF;
  int         slave_base = 0;
  int         fall_cnt = 0;

  initial forever begin
    @(negedge spi_clk);
    fall_cnt++;
  end

  always_comb begin
    int idx;
    idx = 7 - (fall_cnt - slave_base);
    spi_do = (idx >= 0 && idx <= 7) ? slave_seq[idx[2:0]] : 1'b1;
  end

  // Order in which a byte appears on the wire, first bit at [7].
  function automatic logic [7:0] wire_order(input logic [7:0] b);
    logic [7:0] r;
`ifdef SPI_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[7-i] = b[i];
`else
    r = b;
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: sampled on the falling clk edge, checks each completed byte against the queue.
  int         lowcnt = 0;
  int         rises = 0;
  logic [7:0] seq = 8'h00;
  bit         di_zero = 0;
  logic       prev_wait_n = 1'b1;
  logic       prev_sck = 1'b0;

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (wait_n === 1'b0 && prev_wait_n === 1'b1) begin
      lowcnt  = 0;
      rises   = 0;
      seq     = 8'h00;
      di_zero = 0;
    end
    if (wait_n === 1'b0) begin
      lowcnt++;
      if (spi_di !== 1'b1) di_zero = 1;
    end
    if (spi_clk === 1'b1 && prev_sck === 1'b0) begin
      check("sck_rise_only_when_busy", wait_n, 0);
      seq = {seq[6:0], spi_di};
      rises++;
    end
    if (mon_en && wait_n === 1'b1 && prev_wait_n === 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_completion", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sck_rises", rises, 8);
        check("wait_n_low_cycles", lowcnt, 16);
        check(e.recv ? "mosi_recv" : "mosi_send", seq, e.seq);
        check(e.recv ? "dout_recv" : "dout_send", dout, e.dout);
        if (e.recv) check("mosi_idle_during_recv", di_zero, 0);
      end
    end
    prev_wait_n = wait_n;
    prev_sck    = spi_clk;
  end

  // kind: 0 send, 1 receive, 2 both strobes. disturb: cycle of a stray strobe pulse, 0 = none.
  task automatic xfer(input int kind, input logic [7:0] data, input logic [7:0] sbyte,
                      input int disturb);
    exp_t e;
    int   k;
    k = 0;
    while (wait_n !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (wait_n !== 1'b1) check("ready_timeout", wait_n, 1);
    slave_seq    = wire_order(sbyte);
    slave_base   = fall_cnt;
    din          = data;
    enviar_dato  = (kind != 1);
    recibir_dato = (kind != 0);
    e.recv = (kind == 1);
    e.seq  = e.recv ? 8'hFF : wire_order(data);
    if (e.recv) dout_model = sbyte;
    e.dout = dout_model;
    exp_q.push_back(e);
    @(negedge clk);
    enviar_dato  = 1'b0;
    recibir_dato = 1'b0;
    din          = 8'($urandom);
    if (disturb > 0) begin
      repeat (disturb - 1) @(negedge clk);
      if ($urandom_range(0, 1) == 0) recibir_dato = 1'b1;
      else enviar_dato = 1'b1;
      @(negedge clk);
      enviar_dato  = 1'b0;
      recibir_dato = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    rst          = 1'b1;
    enviar_dato  = 1'b0;
    recibir_dato = 1'b0;
    din          = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset must stay at the reset values.
    for (int i = 0; i < 100; i++) begin
      check("idle_after_reset", {wait_n, spi_clk, spi_di, dout}, {1'b1, 1'b0, 1'b1, 8'h00});
      @(negedge clk);
    end

    mon_en = 1;
    xfer(0, 8'h9F, 8'($urandom), 0);
    xfer(1, 8'($urandom), 8'hEF, 0);
    xfer(0, 8'h9F, 8'($urandom), 0);
    xfer(1, 8'($urandom), 8'hC2, 0);
    xfer(0, 8'h9F, 8'($urandom), 5);
    for (int i = 0; i < 40; i++) begin
      xfer(int'($urandom_range(0, 2)), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 14)));
    end

    k = 0;
    while ((exp_q.size() != 0 || wait_n !== 1'b1) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("scoreboard_drained", exp_q.size(), 0);

    // Reset in the middle of a send.
    mon_en      = 0;
    din         = 8'hA5;
    enviar_dato = 1'b1;
    @(negedge clk);
    enviar_dato = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_before_reset", wait_n, 0);
    rst = 1'b1;
    @(negedge clk);
    check("reset_mid_xfer", {wait_n, spi_clk, spi_di, dout}, {1'b1, 1'b0, 1'b1, 8'h00});
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_after_abort", {wait_n, spi_clk, spi_di, dout}, {1'b1, 1'b0, 1'b1, 8'h00});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
